// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between a single-word CPU requester (m0) and an
// incrementing-address burst engine (m1) with round-robin arbitration.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 8,
    parameter int LEN_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_start,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_base,
    input  logic [LEN_W-1:0]      m1_len,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_wready,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_busy,
    output logic                  m1_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      off_q, off_d;
    logic                  we_q, we_d;
    logic                  last_q, last_d;   // 1: m1 was granted most recently
    logic                  rtag0_q, rtag1_q;

    logic                  m0_live;
    logic                  m1_req;
    logic                  gnt0, gnt1;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic                  last_beat;

    // m0 is gated by reset so every output reads 0 while rst_n is low
    assign m0_live    = m0_req & rst_n;
    assign m1_req     = (state_q == RUN);
    assign gnt0       = m0_live & (~m1_req | last_q);
    assign gnt1       = m1_req & (~m0_live | ~last_q);
    assign burst_addr = base_q + ADDR_WIDTH'(off_q);
    assign last_beat  = ((off_q + LEN_W'(1)) == len_q);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        off_d   = off_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (m1_start) begin
                    base_d = m1_base;
                    we_d   = m1_we;
                    off_d  = '0;
                    if (m1_len > LEN_W'(MAX_BURST)) begin
                        len_d = LEN_W'(MAX_BURST);
                    end else begin
                        len_d = m1_len;
                    end
                    state_d = (m1_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (gnt1) begin
                    off_d = off_q + LEN_W'(1);
                    if (last_beat) begin
                        off_d   = '0;
                        state_d = we_q ? DONE : DRAIN;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
            rtag0_q <= 1'b0;
            rtag1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            off_q   <= off_d;
            we_q    <= we_d;
            last_q  <= last_d;
            rtag0_q <= gnt0 & ~m0_we;
            rtag1_q <= gnt1 & ~we_q;
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_we   = 1'b0;
        if (gnt0) begin
            ram_addr = m0_addr;
            ram_data = m0_wdata;
            ram_we   = m0_we;
        end else if (gnt1) begin
            ram_addr = burst_addr;
            ram_data = m1_wdata;
            ram_we   = we_q;
        end
    end

    assign m0_gnt    = gnt0;
    assign m0_rvalid = rtag0_q;
    assign m0_rdata  = rtag0_q ? ram_q : '0;
    assign m1_wready = gnt1 & we_q;
    assign m1_rvalid = rtag1_q;
    assign m1_rdata  = rtag1_q ? ram_q : '0;
    assign m1_busy   = (state_q != IDLE);
    assign m1_done   = (state_q == DONE);

endmodule
